// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch/dmem-wait hazard controller with forwarding, timeout watchdog and perf counters
module hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_we,
  input  logic        ex_is_load,
  input  logic        ex_jb,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_we,
  input  logic        wb_we,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        hold_pc,
  output logic        hold_fd,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        hold_de,
  output logic        hold_em,
  output logic        hold_mw,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [31:0] cnt_stall,
  output logic [31:0] cnt_flush
);
  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;
  state_t state, state_nx, ret, ret_nx, eff;
  logic [1:0] lu_cnt, lu_cnt_nx;
  logic [7:0] to_cnt, to_cnt_nx;
  logic lu_hit, mwait, err_nx;
  assign lu_hit = ex_is_load && ex_we && ex_rd != 5'd0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  assign mwait = dmem_req && !dmem_ready;
  always_comb begin
    {hold_pc, hold_fd, flush_fd, flush_de, hold_de, hold_em, hold_mw} = '0;
    state_nx = state;
    ret_nx = ret;
    lu_cnt_nx = lu_cnt;
    to_cnt_nx = '0;
    err_nx = mem_err;
    // ret remembers the state interrupted by a memory wait; on release we act as that state
    eff = (state == MEM_WAIT) ? ret : state;
    fwd_a = (mem_we && mem_rd != 5'd0 && mem_rd == ex_rs1) ? 2'd1 :
            (wb_we && wb_rd != 5'd0 && wb_rd == ex_rs1) ? 2'd2 : 2'd0;
    fwd_b = (mem_we && mem_rd != 5'd0 && mem_rd == ex_rs2) ? 2'd1 :
            (wb_we && wb_rd != 5'd0 && wb_rd == ex_rs2) ? 2'd2 : 2'd0;
    if (mwait) begin
      {hold_pc, hold_fd, hold_de, hold_em, hold_mw} = '1;
      state_nx = MEM_WAIT;
      ret_nx = eff;
      to_cnt_nx = (to_cnt == 8'(MEM_TIMEOUT)) ? to_cnt : to_cnt + 8'd1;
      err_nx = mem_err || to_cnt_nx == 8'(MEM_TIMEOUT);
    end else if (ex_jb) begin
      {flush_fd, flush_de} = '1;
      state_nx = RUN;
      lu_cnt_nx = '0;
    end else if (eff == LU_STALL) begin
      {hold_pc, hold_fd, flush_de} = '1;
      lu_cnt_nx = lu_cnt - 2'd1;
      state_nx = (lu_cnt == 2'd1) ? RUN : LU_STALL;
    end else begin
      state_nx = RUN;
      if (lu_hit) begin
        {hold_pc, hold_fd, flush_de} = '1;
        lu_cnt_nx = 2'(LU_BUBBLES - 1);
        state_nx = (LU_BUBBLES > 1) ? LU_STALL : RUN;
      end
    end
    if (rst) begin
      {hold_pc, hold_fd, flush_fd, flush_de, hold_de, hold_em, hold_mw} = '0;
      fwd_a = '0;
      fwd_b = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      ret <= RUN;
      lu_cnt <= '0;
      to_cnt <= '0;
      mem_err <= 1'b0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      state <= state_nx;
      ret <= ret_nx;
      lu_cnt <= lu_cnt_nx;
      to_cnt <= to_cnt_nx;
      mem_err <= err_nx;
      cnt_stall <= cnt_stall + 32'(hold_pc | hold_fd | hold_de | hold_em | hold_mw);
      cnt_flush <= cnt_flush + 32'(flush_fd);
    end
  end
endmodule
